kmul_arbiter: RTL and testbench
===============================

KMUL_ARBITER -- requirements
Module: kmul_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one 32x32 multiplier.
REQ-002 Parameter W, default 32: operand width; product width is 2W.
REQ-003 Parameter TIMEOUT, default 64: max WAIT cycles before abort.
REQ-004 Port clk  in  1: single clock, all logic on rising edge.
REQ-005 Port rst  in  1: reset, synchronous, active-high.
REQ-006 Port req  in  NREQ: per-requester request level, held until gnt.
REQ-007 Port req_a, req_b  in  NREQ x W: per-requester operands, valid while req high.
REQ-008 Port gnt  out  NREQ: one-hot one-cycle accept pulse; operands captured that cycle.
REQ-009 Port rsp_valid  out  NREQ: one-hot one-cycle result pulse to owner.
REQ-010 Port rsp_p  out  2W: shared result bus, valid with any rsp_valid bit.
REQ-011 Port rsp_err  out  1: qualifies rsp_valid; high = timeout abort, rsp_p = 0.
REQ-012 Port mul_start  out  1: one-cycle start pulse to multiplier.
REQ-013 Port mul_a, mul_b  out  W: multiplier operands, stable from ISSUE until return to IDLE.
REQ-014 Port mul_p  in  2W, mul_valid  in  1: multiplier product and one-cycle completion pulse.
REQ-015 Port busy  out  1: high in any state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any req bit set, SHALL select winner round-robin starting at (last_owner+1) mod NREQ, pulse gnt[winner], latch operands and owner, go to ISSUE.
REQ-018 IDLE with no req SHALL stay IDLE; no outputs pulse.
REQ-019 ISSUE: SHALL assert mul_start for exactly one cycle, clear wait counter, go to WAIT.
REQ-020 WAIT: on mul_valid SHALL latch mul_p into rsp_p, rsp_err=0, go to RESP.
REQ-021 WAIT: counter increments each cycle without mul_valid; at TIMEOUT-1 SHALL set rsp_p=0, rsp_err=1, go to RESP.
REQ-022 mul_valid and timeout in same cycle: mul_valid SHALL win.
REQ-023 RESP: SHALL pulse rsp_valid[owner] one cycle, update last_owner=owner, go to IDLE.
REQ-024 mul_valid outside WAIT SHALL be ignored.
REQ-025 Latency req->gnt SHALL be 1 cycle from IDLE; gnt->mul_start 1 cycle; mul_valid->rsp_valid 1 cycle.
REQ-026 A requester SHALL NOT be granted again before its rsp_valid; requests arriving while busy wait for IDLE.
REQ-027 With all NREQ requesting continuously, each SHALL be granted once per NREQ transactions.
REQ-028 rsp_p and rsp_err SHALL hold last value between responses.

Reset
REQ-029 On rst: state=IDLE, last_owner=NREQ-1 (requester 0 first priority), counter=0.
REQ-030 On rst: gnt, rsp_valid, mul_start, rsp_err, busy=0; rsp_p, mul_a, mul_b=0.
REQ-031 rst mid-transaction SHALL abort silently, no rsp_valid; late mul_valid ignored.

Structure
REQ-032 Shared package kmul_pkg SHALL hold state enum kmul_arb_state_t and default TIMEOUT constant.
REQ-033 Round-robin pick SHALL be sub-module rr_pick (req vector, last index -> one-hot winner, index).
REQ-034 Multiplier itself is external; no arithmetic inside this block.

Verification
REQ-035 Single req[0], A=0x0001_0000, B=0x0000_FFFF, model returns after 5 cycles -> gnt[0] at cycle 1, mul_start at cycle 2, rsp_valid[0] with rsp_p=0x0000_0000_FFFF_0000.
REQ-036 req=4'b1111 held, 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-037 Model never returns mul_valid -> rsp_valid[owner] with rsp_err=1, rsp_p=0 exactly TIMEOUT cycles after WAIT entry.
REQ-038 mul_valid in cycle TIMEOUT-1 of WAIT -> rsp_err=0, rsp_p=mul_p.
REQ-039 rst asserted in WAIT, mul_valid next cycle -> no rsp_valid, state IDLE, next grant to requester 0.
REQ-040 Spurious mul_valid in IDLE with A=B=0xFFFF_FFFF pending -> ignored; final rsp_p=0xFFFF_FFFE_0000_0001.

Source files
------------

// File: rtl/kmul_pkg.sv
// rtl/kmul_pkg.sv - shared types and constants for the multiplier arbiter
//
// Purpose : FSM state encoding, default abort timeout and an index-width
//           helper shared by kmul_arbiter and rr_pick.
// Ports   : none (package).

package kmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } kmul_arb_state_t;

  // Cycles a transaction may sit in WAIT before it is aborted.
  localparam int KMUL_TIMEOUT_DEFAULT = 64;

  // Width needed to hold an index in 0..n-1; never narrower than one bit
  // so single-requester builds still get a legal vector.
  function automatic int kmul_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin winner selection for kmul_arbiter
//
// Purpose : pick the first set request bit scanning upward from last+1,
//           wrapping modulo NREQ, so the previous owner has lowest priority.
// Ports   : req     in  NREQ  request vector
//           last    in  IW    index of the previous owner
//           win_oh  out NREQ  one-hot winner (all zero when no request)
//           win_idx out IW    binary index of the winner
//           win_any out 1     at least one request present

module rr_pick import kmul_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IW   = kmul_idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            win_any
);

  // Offsets 1..NREQ visit every requester exactly once, ending on last
  // itself, so a lone requester is still chosen when it owned the last slot.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_any && req[(int'(last) + k) % NREQ]) begin
        win_any = 1'b1;
        win_idx = IW'((int'(last) + k) % NREQ);
        win_oh[(int'(last) + k) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kmul_arbiter.sv
// rtl/kmul_arbiter.sv - round-robin arbiter sharing one external multiplier
//
// Purpose : grants one requester at a time access to an external W x W
//           multiplier, forwards the product (or a timeout abort) back to
//           the owner, then rotates priority.
// Ports   : clk, rst             clock, synchronous active-high reset
//           req[NREQ]            request levels, held until gnt
//           req_a/req_b          flattened NREQ x W operands (requester i at i*W)
//           gnt[NREQ]            one-cycle accept pulse, operands captured
//           rsp_valid[NREQ]      one-cycle result pulse to owner
//           rsp_p[2W], rsp_err   shared result bus and abort flag, held
//           mul_start            one-cycle start pulse to multiplier
//           mul_a/mul_b[W]       multiplier operands
//           mul_p[2W], mul_valid multiplier product and completion pulse
//           busy                 transaction in progress

module kmul_arbiter import kmul_pkg::*; #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = KMUL_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*W-1:0]    rsp_p,
  output logic              rsp_err,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_p,
  input  logic              mul_valid,
  output logic              busy
);

  localparam int IW = kmul_idx_w(NREQ);
  localparam int CW = kmul_idx_w(TIMEOUT);

  kmul_arb_state_t state;
  logic [IW-1:0]   last_owner;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   wait_cnt;

  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req     (req),
    .last    (last_owner),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  assign sel_a = req_a[int'(win_idx)*W +: W];
  assign sel_b = req_b[int'(win_idx)*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      // last_owner = NREQ-1 makes requester 0 the first to be served.
      state      <= ST_IDLE;
      last_owner <= IW'(NREQ - 1);
      owner      <= '0;
      wait_cnt   <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_p      <= '0;
      rsp_err    <= 1'b0;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      busy       <= 1'b0;
    end else begin
      // Pulse outputs default low; rsp_p/rsp_err/mul_a/mul_b hold.
      gnt       <= '0;
      rsp_valid <= '0;
      mul_start <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (win_any) begin
            gnt   <= win_oh;
            owner <= win_idx;
            mul_a <= sel_a;
            mul_b <= sel_b;
            busy  <= 1'b1;
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          mul_start <= 1'b1;
          wait_cnt  <= '0;
          state     <= ST_WAIT;
        end

        ST_WAIT: begin
          // A product arriving on the last allowed cycle beats the abort.
          if (mul_valid) begin
            rsp_p     <= mul_p;
            rsp_err   <= 1'b0;
            rsp_valid <= NREQ'(1) << owner;
            state     <= ST_RESP;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_p     <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= NREQ'(1) << owner;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        ST_RESP: begin
          // Priority rotates only once the owner has seen its response.
          last_owner <= owner;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmul_arbiter.sv
// tb/tb_kmul_arbiter.sv - self-checking bench for kmul_arbiter

module tb_kmul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int T    = 10;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [W-1:0]      ra [NREQ];
  logic [W-1:0]      rb [NREQ];
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*W-1:0]    rsp_p;
  logic              rsp_err;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [2*W-1:0]    mul_p;
  logic              mul_valid;
  logic              busy;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_a[gi*W +: W] = ra[gi];
    assign req_b[gi*W +: W] = rb[gi];
  end

  kmul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .rsp_err   (rsp_err),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .mul_valid (mul_valid),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc budget exceeded");
    $fatal(1);
  end

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference: one scheduled transaction with the cycle
  // numbers at which each observable event must appear.
  int          cyc;
  bit          in_txn;
  int          last, owner, idle_from;
  int          g_c, s_c, r_c, mv_c;
  logic [63:0] rp, mvp, hp;
  logic        rerr, herr;
  logic [31:0] ea, eb;
  int          force_d, raise_pct, spur_pct;

  typedef struct {
    int          owner;
    logic [63:0] p;
    logic        err;
  } rsp_t;

  int   obs_gnt_q [$];
  rsp_t obs_rsp_q [$];

  typedef struct {
    logic [NREQ-1:0] mask;
    logic [31:0]     a;
    logic [31:0]     b;
    int              lat;
    bit              spur;
    int              exp_owner;
    logic [63:0]     exp_p;
    logic            exp_err;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int rr_ref(input logic [NREQ-1:0] r, input int lst);
    for (int k = 1; k <= NREQ; k++)
      if (r[(lst + k) % NREQ]) return (lst + k) % NREQ;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic raise(input int i, input logic [31:0] a, input logic [31:0] b);
    req[i] = 1'b1;
    ra[i]  = a;
    rb[i]  = b;
  endtask

  task automatic step();
    int d;
    if (!in_txn && cyc >= idle_from && req != '0) begin
      owner = rr_ref(req, last);
      g_c   = cyc + 1;
      s_c   = cyc + 2;
      d     = (force_d >= 0) ? force_d : int'($urandom_range(1, T + 2));
      ea    = ra[owner];
      eb    = rb[owner];
      mvp   = {32'b0, ea} * {32'b0, eb};
      mv_c  = s_c + d;
      if (d < T) begin
        r_c = s_c + d + 1; rp = mvp; rerr = 1'b0;
      end else begin
        r_c = s_c + T; rp = '0; rerr = 1'b1;
      end
      in_txn = 1'b1;
    end

    @(negedge clk);
    cyc++;

    if (gnt != '0) obs_gnt_q.push_back(oh_idx(gnt));
    if (rsp_valid != '0) obs_rsp_q.push_back(rsp_t'{oh_idx(rsp_valid), rsp_p, rsp_err});
    if (in_txn && cyc == r_c) begin
      hp   = rp;
      herr = rerr;
    end
    chk("gnt", gnt, (in_txn && cyc == g_c) ? (64'd1 << owner) : 64'd0);
    chk("mul_start", mul_start, in_txn && cyc == s_c);
    chk("rsp_valid", rsp_valid, (in_txn && cyc == r_c) ? (64'd1 << owner) : 64'd0);
    chk("busy", busy, in_txn && cyc >= g_c && cyc <= r_c);
    chk("rsp_p", rsp_p, hp);
    chk("rsp_err", rsp_err, herr);
    if (in_txn && cyc >= s_c && cyc <= r_c) begin
      chk("mul_a", mul_a, ea);
      chk("mul_b", mul_b, eb);
    end
    if (in_txn && cyc == r_c) begin
      in_txn    = 1'b0;
      last      = owner;
      idle_from = cyc + 1;
    end

    if (in_txn && cyc == g_c) req[owner] = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (!req[i] && !(in_txn && owner == i) && int'($urandom_range(0, 99)) < raise_pct)
        raise(i, $urandom, $urandom);
    mul_valid = (cyc == mv_c);
    mul_p     = (cyc == mv_c) ? mvp : {$urandom, $urandom};
    if (!mul_valid && !(in_txn && cyc >= s_c && cyc < r_c) &&
        int'($urandom_range(0, 99)) < spur_pct)
      mul_valid = 1'b1;
  endtask

  task automatic do_reset(input logic late_mv);
    rst       = 1'b1;
    req       = '0;
    mul_valid = 1'b0;
    mul_p     = '0;
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_p", rsp_p, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    rst       = 1'b0;
    mul_valid = late_mv;
    mul_p     = 64'h0BAD_0BAD_0BAD_0BAD;
    cyc       = 0;
    in_txn    = 1'b0;
    last      = NREQ - 1;
    idle_from = 0;
    hp        = '0;
    herr      = 1'b0;
    g_c = -100; s_c = -100; r_c = -100; mv_c = -100;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int tgt;
    int b;
    tgt = obs_rsp_q.size() + n;
    b   = budget;
    while (obs_rsp_q.size() < tgt && b > 0) begin
      step();
      b--;
    end
    chk("rsp_budget", obs_rsp_q.size() >= tgt, 1);
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while ((req != '0 || in_txn) && b > 0) begin
      step();
      b--;
    end
    step();
    step();
  endtask

  initial begin
    int base, gbase;

    req = '0; mul_valid = 1'b0; mul_p = '0; rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; end
    force_d = -1; raise_pct = 0; spur_pct = 0; cyc = 0;

    vt[0] = '{4'b0001, 32'h0001_0000, 32'h0000_FFFF, 5,     1'b0, 0, 64'h0000_0000_FFFF_0000, 1'b0};
    vt[1] = '{4'b0110, 32'hFFFF_FFFF, 32'h0000_0002, 3,     1'b0, 1, 64'h0000_0001_FFFF_FFFE, 1'b0};
    vt[2] = '{4'b1001, 32'h1234_5678, 32'h0000_0010, T,     1'b0, 3, 64'h0,                   1'b1};
    vt[3] = '{4'b1010, 32'h8000_0000, 32'h8000_0000, T - 1, 1'b0, 1, 64'h4000_0000_0000_0000, 1'b0};
    vt[4] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,     1'b1, 0, 64'hFFFF_FFFE_0000_0001, 1'b0};

    // Directed vectors: first response owner/value, then final bus value.
    do_reset(1'b0);
    for (int v = 0; v < 5; v++) begin
      if (v > 0) step();
      for (int i = 0; i < NREQ; i++)
        if (vt[v].mask[i]) raise(i, vt[v].a, vt[v].b);
      if (vt[v].spur) begin
        mul_valid = 1'b1;
        mul_p     = 64'h0123_4567_89AB_CDEF;
      end
      force_d = vt[v].lat;
      base    = obs_rsp_q.size();
      wait_rsp($countones(vt[v].mask), 300);
      if (obs_rsp_q.size() > base) begin
        chk("vec_owner", obs_rsp_q[base].owner, vt[v].exp_owner);
        chk("vec_p", obs_rsp_q[base].p, vt[v].exp_p);
        chk("vec_err", obs_rsp_q[base].err, vt[v].exp_err);
      end else begin
        chk("vec_rsp_seen", obs_rsp_q.size(), base + 1);
      end
      step();
      chk("vec_final_p", rsp_p, vt[v].exp_p);
      chk("vec_final_err", rsp_err, vt[v].exp_err);
    end

    // All requesters asking continuously: strict rotation from requester 0.
    do_reset(1'b0);
    force_d   = 2;
    raise_pct = 100;
    gbase     = obs_gnt_q.size();
    wait_rsp(8, 400);
    raise_pct = 0;
    for (int k = 0; k < 8; k++) begin
      if (obs_gnt_q.size() > gbase + k) chk("rr_order", obs_gnt_q[gbase + k], k % 4);
      else chk("rr_order_seen", obs_gnt_q.size(), gbase + k + 1);
    end
    drain(400);

    // Reset while waiting on the multiplier, late product right after.
    do_reset(1'b0);
    force_d = 2;
    raise(0, 32'd5, 32'd6);
    wait_rsp(1, 100);
    step();
    raise(1, 32'd7, 32'd8);
    force_d = T + 2;
    for (int k = 0; k < 50 && !(in_txn && cyc == s_c + 2); k++) step();
    do_reset(1'b1);
    base  = obs_rsp_q.size();
    gbase = obs_gnt_q.size();
    step(); step(); step();
    chk("rst_silent", obs_rsp_q.size(), base);
    force_d = 2;
    for (int i = 0; i < NREQ; i++) raise(i, 32'd3, 32'd3);
    wait_rsp(4, 300);
    if (obs_gnt_q.size() > gbase) chk("rst_next_gnt", obs_gnt_q[gbase], 0);
    else chk("rst_next_gnt_seen", obs_gnt_q.size(), gbase + 1);
    drain(200);

    // Randomized traffic with random latencies, timeouts and stray pulses.
    do_reset(1'b0);
    force_d   = -1;
    raise_pct = 30;
    spur_pct  = 20;
    repeat (1500) step();
    raise_pct = 0;
    spur_pct  = 0;
    drain(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
